lcm_req_master: RTL and testbench

- Requester side of the lcm operand/result interface: drives A, B and a one-cycle vld_in pulse, then waits for vld_out and captures lcm_out and mcd_out.
- Accepts operand pairs from an upstream valid/ready stream and returns each result on a downstream valid/ready stream.
- Self-checks every result against lcm*mcd == A*B, counts errors and times out a non-responding lcm.
- Sits between a host/sequencer and an lcm instance, one transaction in flight.

---
 rtl/lcm_req_master.sv | 124 ++++++++++++
 tb/tb_lcm_req_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcm_req_master.sv
// Requester for an lcm/gcd engine: issues one operand pair at a time, captures and self-checks the result.
// Nonzero pair: result valid the cycle after vld_out; zero operand: result valid the cycle after accept.
module lcm_req_master #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic                  op_valid,
  output logic                  op_ready,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  output logic                  vld_in,
  input  logic [2*DATA_W-1:0]   lcm_out,
  input  logic [DATA_W-1:0]     mcd_out,
  input  logic                  vld_out,
  output logic [2*DATA_W-1:0]   res_lcm,
  output logic [DATA_W-1:0]     res_mcd,
  output logic [DATA_W-1:0]     res_a,
  output logic [DATA_W-1:0]     res_b,
  output logic                  res_err,
  output logic                  res_timeout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int PW = 3 * DATA_W;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] prod_res, prod_op;
  logic          chk_err;
  logic          zero_op;
  logic          accept;

  assign zero_op = (op_a == '0) || (op_b == '0);
  assign accept  = (state == IDLE) && op_valid;

  // Both products are widened to 3*DATA_W so the full lcm*gcd range compares exactly.
  assign prod_res = PW'(lcm_out) * PW'(mcd_out);
  assign prod_op  = PW'(A) * PW'(B);
  assign chk_err  = (prod_res != prod_op) || (mcd_out == '0);

  assign op_ready  = (state == IDLE);
  assign vld_in    = (state == ISSUE);
  assign res_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (op_valid) state_nxt = zero_op ? HOLD : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (vld_out || (tcnt == T_LAST)) state_nxt = HOLD;
      HOLD:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A           <= '0;
      B           <= '0;
      tcnt        <= '0;
      res_lcm     <= '0;
      res_mcd     <= '0;
      res_a       <= '0;
      res_b       <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (accept) begin
        A     <= op_a;
        B     <= op_b;
        res_a <= op_a;
        res_b <= op_b;
        // lcm(x,0)=0 and gcd(x,0)=x, so the engine is bypassed.
        if (zero_op) begin
          res_lcm     <= '0;
          res_mcd     <= op_a | op_b;
          res_err     <= 1'b0;
          res_timeout <= 1'b0;
        end
      end
      if (state == ISSUE) tcnt <= '0;
      if (state == WAIT) begin
        if (vld_out) begin
          res_lcm     <= lcm_out;
          res_mcd     <= mcd_out;
          res_err     <= chk_err;
          res_timeout <= 1'b0;
        end else if (tcnt == T_LAST) begin
          res_lcm     <= '0;
          res_mcd     <= '0;
          res_err     <= 1'b0;
          res_timeout <= 1'b1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((state == HOLD) && res_ready && (res_err || res_timeout) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lcm_req_master.sv
// Directed bench for lcm_req_master with a behavioural lcm responder driven from hand-set answers.
module tb_lcm_req_master;

  logic        clk;
  logic        rst_n;
  logic [7:0]  op_a, op_b;
  logic        op_valid, op_ready;
  logic [7:0]  A, B;
  logic        vld_in;
  logic [15:0] lcm_out;
  logic [7:0]  mcd_out;
  logic        vld_out;
  logic [15:0] res_lcm;
  logic [7:0]  res_mcd, res_a, res_b;
  logic        res_err, res_timeout, res_valid, res_ready;
  logic [1:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fire = -1;
  int inj = -1;
  int vld_cnt = 0;
  int m_delay = 6;
  logic m_en = 1'b1;
  int rdy_hi = 0;
  int n_lat;
  int base;
  int bad;

  lcm_req_master #(.DATA_W(8), .TIMEOUT(16), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .A(A), .B(B), .vld_in(vld_in),
    .lcm_out(lcm_out), .mcd_out(mcd_out), .vld_out(vld_out),
    .res_lcm(res_lcm), .res_mcd(res_mcd), .res_a(res_a), .res_b(res_b),
    .res_err(res_err), .res_timeout(res_timeout), .res_valid(res_valid),
    .res_ready(res_ready), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: answers m_delay cycles after each vld_in; inj forces one extra pulse.
  initial begin
    vld_out = 1'b0;
    forever begin
      @(negedge clk);
      vld_out = (cyc == fire) || (cyc == inj);
      if (vld_in) begin
        vld_cnt++;
        if (m_en) fire = cyc + m_delay;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    rdy_hi = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (res_valid) break;
      if (op_ready) rdy_hi++;
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    op_a = '0; op_b = '0; op_valid = 1'b0; res_ready = 1'b0;
    lcm_out = '0; mcd_out = '0;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_vld_in", vld_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_res_lcm", res_lcm, 0);
    chk("rst_A", A, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // (12,20): single issue, long HOLD with res_ready low
    lcm_out = 16'd60; mcd_out = 8'd4; m_delay = 6;
    base = vld_cnt;
    send(8'd12, 8'd20);
    chk("issue_vld_in", vld_in, 1);
    chk("issue_op_ready", op_ready, 0);
    chk("issue_A", A, 12);
    chk("issue_B", B, 20);
    wait_res(n_lat);
    chk("t1_latency", n_lat, 7);
    chk("t1_lcm", res_lcm, 60);
    chk("t1_mcd", res_mcd, 4);
    chk("t1_err", res_err, 0);
    chk("t1_res_a", res_a, 12);
    chk("t1_res_b", res_b, 20);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!res_valid || op_ready || vld_in || res_lcm != 16'd60 || res_mcd != 8'd4) bad++;
    end
    chk("t1_hold_stable", bad, 0);
    chk("t1_one_pulse", vld_cnt - base, 1);
    handshake();
    chk("t1_valid_drop", res_valid, 0);
    chk("t1_ready_back", op_ready, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // back-to-back (12,20) then (15,21)
    base = vld_cnt;
    res_ready = 1'b1;
    send(8'd12, 8'd20);
    wait_res(n_lat);
    chk("b2b1_latency", n_lat, 7);
    chk("b2b1_lcm", res_lcm, 60);
    chk("b2b1_ready_low", rdy_hi, 0);
    @(negedge clk);
    chk("b2b1_ready_rise", op_ready, 1);
    lcm_out = 16'd105; mcd_out = 8'd3;
    send(8'd15, 8'd21);
    wait_res(n_lat);
    chk("b2b2_latency", n_lat, 7);
    chk("b2b2_lcm", res_lcm, 105);
    chk("b2b2_mcd", res_mcd, 3);
    chk("b2b2_ready_low", rdy_hi, 0);
    @(negedge clk);
    res_ready = 1'b0;
    chk("b2b_pulses", vld_cnt - base, 2);
    chk("b2b_err_cnt", err_cnt, 0);

    // zero operand bypass
    base = vld_cnt;
    send(8'd0, 8'd9);
    chk("zero_valid", res_valid, 1);
    chk("zero_lcm", res_lcm, 0);
    chk("zero_mcd", res_mcd, 9);
    chk("zero_err", res_err, 0);
    handshake();
    chk("zero_no_pulse", vld_cnt - base, 0);

    // wrong gcd flagged, then full-width correct pair
    lcm_out = 16'd60; mcd_out = 8'd5;
    send(8'd12, 8'd20);
    wait_res(n_lat);
    chk("bad_err", res_err, 1);
    handshake();
    chk("bad_err_cnt", err_cnt, 1);
    lcm_out = 16'd64770; mcd_out = 8'd1;
    send(8'd255, 8'd254);
    wait_res(n_lat);
    chk("wide_lcm", res_lcm, 64770);
    chk("wide_err", res_err, 0);
    handshake();
    chk("wide_err_cnt", err_cnt, 1);

    // silent engine -> timeout; late answer ignored
    m_en = 1'b0;
    send(8'd3, 8'd5);
    wait_res(n_lat);
    chk("to_latency", n_lat, 17);
    chk("to_flag", res_timeout, 1);
    chk("to_lcm", res_lcm, 0);
    chk("to_mcd", res_mcd, 0);
    lcm_out = 16'd77; mcd_out = 8'd7;
    inj = cyc + 3;
    repeat (4) @(negedge clk);
    chk("late_lcm", res_lcm, 0);
    chk("late_timeout", res_timeout, 1);
    chk("late_valid", res_valid, 1);
    handshake();
    chk("to_err_cnt", err_cnt, 2);
    m_en = 1'b1;

    // saturation of the 2-bit counter
    lcm_out = 16'd63; mcd_out = 8'd2;
    send(8'd7, 8'd9);
    wait_res(n_lat);
    handshake();
    chk("sat_cnt3", err_cnt, 3);
    lcm_out = 16'd5; mcd_out = 8'd0;
    send(8'd5, 8'd5);
    wait_res(n_lat);
    chk("mcd0_err", res_err, 1);
    handshake();
    chk("sat_hold", err_cnt, 3);

    // reset during WAIT, pending answer must be ignored
    lcm_out = 16'd60; mcd_out = 8'd4;
    send(8'd12, 8'd20);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_vld_in", vld_in, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_op_ready", op_ready, 1);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_A", A, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = vld_cnt;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid || vld_in || !op_ready || res_lcm != 16'd0) bad++;
    end
    chk("arst_ignore", bad, 0);
    chk("arst_no_pulse", vld_cnt - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
